// File: rtl/alu_multibyte_sequencer.sv
// Multi-byte command sequencer for the 8-bit ALU.
// Issues one wide op LSB-first, chains carry/borrow, holds the result.
module alu_multibyte_sequencer #(
    parameter int         NBYTES  = 4,
    parameter int         ALU_LAT = 1,
    parameter logic [4:0] SEL_ADC = 5'b00001,
    parameter logic [4:0] SEL_SBB = 5'b00011,
    parameter logic [4:0] SEL_AND = 5'b00100,
    parameter logic [4:0] SEL_OR  = 5'b00101,
    parameter logic [4:0] SEL_XOR = 5'b00110
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [8*NBYTES-1:0] cmd_a,
    input  logic [8*NBYTES-1:0] cmd_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8*NBYTES-1:0] res_data,
    output logic                res_zero,
    output logic                res_sign,
    output logic                res_carry,
    output logic                res_overflow,
    output logic                res_err,
    output logic [4:0]          alu_sel,
    output logic [7:0]          alu_in_1,
    output logic [7:0]          alu_in_2,
    output logic                alu_in_carry,
    input  logic [7:0]          alu_out,
    input  logic                alu_carry_flag,
    input  logic                alu_overflow_flag
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 2) ? $clog2(NBYTES) : 1;
    localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);
    localparam logic [WW-1:0] WLAST = WW'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_d;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [KW-1:0] k;
    logic [WW-1:0] wcnt;
    logic          accept;
    logic          byte_done;
    logic          legal;
    logic          arith;
    int            byte_lo;
    logic [W-1:0]  res_full;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;

    function automatic logic [4:0] sel_of(input logic [2:0] op);
        logic [4:0] s;
        unique case (op)
            3'd0:    s = SEL_ADC;
            3'd1:    s = SEL_SBB;
            3'd2:    s = SEL_AND;
            3'd3:    s = SEL_OR;
            3'd4:    s = SEL_XOR;
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign legal     = (cmd_op <= 3'd4);
    // Only ADD/SUB propagate carry/borrow between bytes.
    assign arith     = (op_q[2:1] == 2'b00);

    always_comb begin
        byte_lo  = 8 * int'(k);
        res_full = res_data;
        res_full[byte_lo +: 8] = alu_out;
        a_sh     = a_q >> (byte_lo + 8);
        b_sh     = b_q >> (byte_lo + 8);
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        byte_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = legal ? RUN : DONE;
                end
            end
            RUN: begin
                if (wcnt == WLAST) begin
                    byte_done = 1'b1;
                    if (k == KLAST) state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state <= IDLE;
        else           state <= state_d;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            k            <= '0;
            wcnt         <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_zero     <= 1'b0;
            res_sign     <= 1'b0;
            res_carry    <= 1'b0;
            res_overflow <= 1'b0;
            res_err      <= 1'b0;
            alu_sel      <= '0;
            alu_in_1     <= '0;
            alu_in_2     <= '0;
            alu_in_carry <= 1'b0;
        end else if (accept) begin
            op_q    <= cmd_op;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            res_err <= !legal;
            if (legal) begin
                alu_sel      <= sel_of(cmd_op);
                alu_in_1     <= cmd_a[7:0];
                alu_in_2     <= cmd_b[7:0];
                alu_in_carry <= 1'b0;
                k            <= '0;
                wcnt         <= '0;
            end else begin
                res_data     <= '0;
                res_zero     <= 1'b1;
                res_sign     <= 1'b0;
                res_carry    <= 1'b0;
                res_overflow <= 1'b0;
                res_valid    <= 1'b1;
            end
        end else if (state == RUN) begin
            if (byte_done) begin
                res_data <= res_full;
                if (k != KLAST) begin
                    k            <= k + 1'b1;
                    wcnt         <= '0;
                    alu_in_1     <= a_sh[7:0];
                    alu_in_2     <= b_sh[7:0];
                    alu_in_carry <= arith & alu_carry_flag;
                end else begin
                    res_zero     <= (res_full == '0);
                    res_sign     <= res_full[W-1];
                    res_carry    <= arith & alu_carry_flag;
                    res_overflow <= arith & alu_overflow_flag;
                    res_valid    <= 1'b1;
                end
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end else if (state == DONE && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_multibyte_sequencer.sv
// Directed bench for alu_multibyte_sequencer with a behavioural 8-bit ALU.
// NBYTES=4, ALU_LAT=1.
module tb_alu_multibyte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_sign;
    logic        res_carry;
    logic        res_overflow;
    logic        res_err;
    logic [4:0]  alu_sel;
    logic [7:0]  alu_in_1;
    logic [7:0]  alu_in_2;
    logic        alu_in_carry;
    logic [7:0]  alu_out;
    logic        alu_carry_flag;
    logic        alu_overflow_flag;

    int passed = 0;
    int total  = 0;

    alu_multibyte_sequencer #(.NBYTES(4), .ALU_LAT(1)) dut (
        .in_clk            (clk),
        .in_rst_n          (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_a             (cmd_a),
        .cmd_b             (cmd_b),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .res_zero          (res_zero),
        .res_sign          (res_sign),
        .res_carry         (res_carry),
        .res_overflow      (res_overflow),
        .res_err           (res_err),
        .alu_sel           (alu_sel),
        .alu_in_1          (alu_in_1),
        .alu_in_2          (alu_in_2),
        .alu_in_carry      (alu_in_carry),
        .alu_out           (alu_out),
        .alu_carry_flag    (alu_carry_flag),
        .alu_overflow_flag (alu_overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational on the registered operands.
    always_comb begin
        logic [8:0] t;
        t                 = '0;
        alu_out           = '0;
        alu_carry_flag    = 1'b0;
        alu_overflow_flag = 1'b0;
        case (alu_sel)
            5'b00001: begin
                t = {1'b0, alu_in_1} + {1'b0, alu_in_2} + {8'd0, alu_in_carry};
                alu_out = t[7:0];
                alu_carry_flag = t[8];
                alu_overflow_flag = (alu_in_1[7] == alu_in_2[7]) && (t[7] != alu_in_1[7]);
            end
            5'b00011: begin
                t = {1'b0, alu_in_1} - {1'b0, alu_in_2} - {8'd0, alu_in_carry};
                alu_out = t[7:0];
                alu_carry_flag = t[8];
                alu_overflow_flag = (alu_in_1[7] != alu_in_2[7]) && (t[7] != alu_in_1[7]);
            end
            5'b00100: alu_out = alu_in_1 & alu_in_2;
            5'b00101: alu_out = alu_in_1 | alu_in_2;
            5'b00110: alu_out = alu_in_1 ^ alu_in_2;
            default:  alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present one command; lat = edges after accept until res_valid.
    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [3:0] cs);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        cs = '0;
        while (!res_valid && lat < 20) begin
            if (lat < 4) cs[lat] = alu_in_carry;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_timeout"}, 64'(lat < 20), 64'd1);
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk({tag, "_drop"}, 64'(res_valid), 64'd0);
        chk({tag, "_rdy"}, 64'(cmd_ready), 64'd1);
    endtask

    // ef = {zero, sign, carry, overflow, err}
    task automatic run_vec(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ed, input logic [4:0] ef,
                           input int elat);
        int lat;
        logic [3:0] cs;
        issue(tag, op, a, b, lat, cs);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_data"}, 64'(res_data), 64'(ed));
        chk({tag, "_flags"},
            64'({res_zero, res_sign, res_carry, res_overflow, res_err}),
            64'(ef));
        take(tag);
    endtask

    initial begin
        int lat;
        logic [3:0] cs;
        logic stable;
        logic seen;

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs",
            64'({res_valid, res_zero, res_sign, res_carry, res_overflow, res_err}),
            64'd0);
        chk("rst_alu", 64'({alu_sel, alu_in_1, alu_in_2, alu_in_carry}), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rel_ready", 64'(cmd_ready), 64'd1);

        run_vec("add_ff", 3'd0, 32'h000000FF, 32'h00000001, 32'h00000100, 5'b00000, 4);
        run_vec("add_wrap", 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100, 4);
        run_vec("add_ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010, 4);

        issue("sub_neg", 3'd1, 32'h00000000, 32'h00000001, lat, cs);
        chk("sub_neg_lat", 64'(lat), 64'd4);
        chk("sub_neg_data", 64'(res_data), 64'hFFFFFFFF);
        chk("sub_neg_flags",
            64'({res_zero, res_sign, res_carry, res_overflow, res_err}),
            64'(5'b01100));
        chk("sub_neg_cin", 64'(cs), 64'(4'b1110));
        take("sub_neg");

        run_vec("sub_pos", 3'd1, 32'h10000000, 32'h00000001, 32'h0FFFFFFF, 5'b00000, 4);
        run_vec("and", 3'd2, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 5'b00000, 4);
        run_vec("or", 3'd3, 32'h12345678, 32'h80000001, 32'h92345679, 5'b01000, 4);
        run_vec("xor", 3'd4, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 5'b01000, 4);
        chk("xor_sel", 64'(alu_sel), 64'(5'b00110));

        // Illegal op: result is visible straight after the accept edge.
        run_vec("ill", 3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10001, 0);
        chk("ill_sel", 64'(alu_sel), 64'(5'b00110));

        // Backpressure: result held, new command refused.
        issue("hold", 3'd0, 32'h00000001, 32'h00000002, lat, cs);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmd_op = 3'd2;
            cmd_a = 32'h55555555;
            cmd_b = 32'hFFFFFFFF;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            if (res_data !== 32'h3 || !res_valid || cmd_ready || res_err)
                stable = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("hold_stable", 64'(stable), 64'd1);
        chk("hold_alu", 64'({alu_sel, alu_in_1}), 64'({5'b00001, 8'h00}));
        take("hold");

        // Reset during byte 2 of an operation.
        @(negedge clk);
        cmd_op = 3'd0;
        cmd_a = 32'h11223344;
        cmd_b = 32'h01010101;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("rst_byte2", 64'(alu_in_1), 64'h22);
        rst_n = 1'b0;
        #1;
        chk("arst_outs",
            64'({res_valid, res_zero, res_sign, res_carry, res_overflow, res_err}),
            64'd0);
        chk("arst_alu", 64'({alu_sel, alu_in_1, alu_in_2, alu_in_carry}), 64'd0);
        chk("arst_data", 64'(res_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        @(posedge clk);
        #1 chk("arst_ready", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("arst_novalid", 64'(seen), 64'd0);

        run_vec("post_rst", 3'd0, 32'h00000001, 32'h00000001, 32'h00000002, 5'b00000, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
